// File: rtl/counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_pkg : shared constants and width helper for the counter IP   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package counter_pkg;

  localparam logic CNT_DOWN  = 1'b0;
  localparam logic CNT_UP    = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_updown_counter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_updown_counter_if : control/status bundle of the counter        |
// | Revision               : 1.0                                         |
// +----------------------------------------------------------------------+
interface sync_updown_counter_if #(
  parameter int N = 4
);
  logic         enable;
  logic         up_down;
  logic         clear;
  logic         load;
  logic [N-1:0] load_value;
  logic [N-1:0] Q;
  logic         tc;
  logic         wrap;

  modport master (
    output enable, up_down, clear, load, load_value,
    input  Q, tc, wrap
  );

  modport slave (
    input  enable, up_down, clear, load, load_value,
    output Q, tc, wrap
  );
endinterface
`default_nettype wire

// File: rtl/sync_updown_counter_tick_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_prescaler : issues one tick every PRESCALE enabled cycles        |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, reset_n, restart};
      assign tick = enable;
    end else begin : g_count
      localparam int W = clog2(PRESCALE);
      localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

      logic [W-1:0] pcnt_q;
      logic [W-1:0] pcnt_d;

      assign tick = enable & (pcnt_q == LAST);

      always_comb begin
        pcnt_d = pcnt_q;
        if (restart) begin
          pcnt_d = '0;
        end else if (enable) begin
          pcnt_d = (pcnt_q == LAST) ? '0 : pcnt_q + W'(1);
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pcnt_q <= '0;
        else          pcnt_q <= pcnt_d;
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/sync_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_updown_counter : modulo up/down counter, wrap/saturate, cascade |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int N        = 4,
  parameter int MOD      = 2**N,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  sync_updown_counter_if.slave      bus
);

  localparam logic [N-1:0] MAX = N'(MOD - 1);

  logic         tick;
  logic         at_limit;
  logic         tc;
  logic [N-1:0] load_clamped;
  logic [N-1:0] q_q;
  logic [N-1:0] q_d;
  logic         wrap_q;
  logic         wrap_d;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (bus.enable),
    .restart (bus.clear | bus.load),
    .tick    (tick)
  );

  assign at_limit     = (bus.up_down == CNT_UP) ? (q_q == MAX) : (q_q == '0);
  assign tc           = tick & ~bus.clear & ~bus.load & at_limit;
  assign load_clamped = (bus.load_value > MAX) ? MAX : bus.load_value;

  // tc already excludes clear/load, so it doubles as the next wrap value
  always_comb begin
    q_d    = q_q;
    wrap_d = tc;
    if (bus.clear) begin
      q_d = '0;
    end else if (bus.load) begin
      q_d = load_clamped;
    end else if (tick) begin
      if (at_limit) begin
        if (SATURATE == int'(MODE_WRAP)) begin
          q_d = (bus.up_down == CNT_UP) ? '0 : MAX;
        end
      end else begin
        q_d = (bus.up_down == CNT_UP) ? q_q + N'(1) : q_q - N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.tc   = tc;
  assign bus.wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sync_updown_counter : scoreboard bench for sync_updown_counter    |
// | Revision               : 1.0                                         |
// +----------------------------------------------------------------------+
module tb_sync_updown_counter;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic reset_n;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // model state per instance: 0 = wrap, 1 = saturate, 2 = prescale-by-3
  int        mq[3];
  int        mw[3];
  int        mp[3];
  const int  PS[3]  = '{1, 1, 3};
  const int  SAT[3] = '{0, 1, 0};

  sync_updown_counter_if #(.N(4)) if_wrap ();
  sync_updown_counter_if #(.N(4)) if_sat ();
  sync_updown_counter_if #(.N(4)) if_pre ();
  sync_updown_counter_if #(.N(4)) if_lo ();
  sync_updown_counter_if #(.N(4)) if_hi ();

  sync_updown_counter #(.N(4), .MOD(10), .SATURATE(0), .PRESCALE(1)) u_wrap (
    .clk(clk), .reset_n(reset_n), .bus(if_wrap));
  sync_updown_counter #(.N(4), .MOD(10), .SATURATE(1), .PRESCALE(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .bus(if_sat));
  sync_updown_counter #(.N(4), .MOD(10), .SATURATE(0), .PRESCALE(3)) u_pre (
    .clk(clk), .reset_n(reset_n), .bus(if_pre));
  sync_updown_counter #(.N(4), .MOD(10), .SATURATE(0), .PRESCALE(1)) u_lo (
    .clk(clk), .reset_n(reset_n), .bus(if_lo));
  sync_updown_counter #(.N(4), .MOD(10), .SATURATE(0), .PRESCALE(1)) u_hi (
    .clk(clk), .reset_n(reset_n), .bus(if_hi));

  assign if_hi.enable = if_lo.tc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input int v);
    exp_t e;
    e.tag = tag;
    e.val = 32'(v);
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %0d required an entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [31:0] oq(input int s);
    case (s)
      0:       return 32'(if_wrap.Q);
      1:       return 32'(if_sat.Q);
      default: return 32'(if_pre.Q);
    endcase
  endfunction

  function automatic logic [31:0] otc(input int s);
    case (s)
      0:       return 32'(if_wrap.tc);
      1:       return 32'(if_sat.tc);
      default: return 32'(if_pre.tc);
    endcase
  endfunction

  function automatic logic [31:0] ow(input int s);
    case (s)
      0:       return 32'(if_wrap.wrap);
      1:       return 32'(if_sat.wrap);
      default: return 32'(if_pre.wrap);
    endcase
  endfunction

  task automatic drive(input int s, input logic en, input logic ud,
                       input logic clr, input logic ld, input logic [3:0] lv);
    case (s)
      0: begin if_wrap.enable = en; if_wrap.up_down = ud; if_wrap.clear = clr;
               if_wrap.load = ld; if_wrap.load_value = lv; end
      1: begin if_sat.enable = en; if_sat.up_down = ud; if_sat.clear = clr;
               if_sat.load = ld; if_sat.load_value = lv; end
      default: begin if_pre.enable = en; if_pre.up_down = ud; if_pre.clear = clr;
               if_pre.load = ld; if_pre.load_value = lv; end
    endcase
  endtask

  function automatic int nxt(input int q, input bit up, input int sat);
    if (up) return (q == 9) ? ((sat != 0) ? 9 : 0) : q + 1;
    else    return (q == 0) ? ((sat != 0) ? 0 : 9) : q - 1;
  endfunction

  // enabled counting for a number of cycles; tc checked before each edge
  task automatic run(input int s, input int cycles, input bit up);
    bit tick;
    bit lim;
    for (int i = 0; i < cycles; i++) begin
      drive(s, 1'b1, up, 1'b0, 1'b0, 4'd0);
      #1;
      tick = (mp[s] == PS[s] - 1);
      lim  = up ? (mq[s] == 9) : (mq[s] == 0);
      push($sformatf("s%0d_tc", s), int'(tick & lim));
      check(otc(s));
      mp[s] = tick ? 0 : mp[s] + 1;
      mw[s] = int'(tick & lim);
      if (tick) mq[s] = nxt(mq[s], up, SAT[s]);
      @(posedge clk); #1;
      push($sformatf("s%0d_q", s), mq[s]);    check(oq(s));
      push($sformatf("s%0d_wrap", s), mw[s]); check(ow(s));
    end
  endtask

  task automatic hold(input int s, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      drive(s, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      #1;
      push($sformatf("s%0d_hold_tc", s), 0); check(otc(s));
      mw[s] = 0;
      @(posedge clk); #1;
      push($sformatf("s%0d_hold_q", s), mq[s]);    check(oq(s));
      push($sformatf("s%0d_hold_wrap", s), 0);      check(ow(s));
    end
  endtask

  task automatic load_step(input int s, input logic clr, input logic ld,
                           input logic [3:0] lv, input bit up);
    drive(s, 1'b1, up, clr, ld, lv);
    #1;
    push($sformatf("s%0d_ld_tc", s), 0); check(otc(s));
    mq[s] = clr ? 0 : ((int'(lv) > 9) ? 9 : int'(lv));
    mp[s] = 0;
    mw[s] = 0;
    @(posedge clk); #1;
    push($sformatf("s%0d_ld_q", s), mq[s]); check(oq(s));
    push($sformatf("s%0d_ld_wrap", s), 0);  check(ow(s));
  endtask

  // idle everything, then pulse reset between clock edges
  task automatic do_reset();
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    if_lo.enable = 1'b0; if_lo.up_down = 1'b1; if_lo.clear = 1'b0;
    if_lo.load = 1'b0; if_lo.load_value = 4'd0;
    if_hi.up_down = 1'b1; if_hi.clear = 1'b0; if_hi.load = 1'b0; if_hi.load_value = 4'd0;
    #2;
    reset_n = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      push($sformatf("s%0d_rst_q", s), 0);    check(oq(s));
      push($sformatf("s%0d_rst_wrap", s), 0); check(ow(s));
      push($sformatf("s%0d_rst_tc", s), 0);   check(otc(s));
      mq[s] = 0; mw[s] = 0; mp[s] = 0;
    end
    push("cas_rst_lo", 0); check(32'(if_lo.Q));
    push("cas_rst_hi", 0); check(32'(if_hi.Q));
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int cnt;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // up count through the modulus
    run(0, 12, 1'b1);

    // down count from reset: first tick wraps to 9
    @(posedge clk); #1;
    do_reset();
    run(0, 5, 1'b0);

    // saturate mode at both limits
    @(posedge clk); #1;
    do_reset();
    load_step(1, 1'b0, 1'b1, 4'd8, 1'b1);
    run(1, 4, 1'b1);
    run(1, 2, 1'b0);
    load_step(1, 1'b0, 1'b1, 4'd0, 1'b0);
    run(1, 2, 1'b0);

    // prescaler, enable gaps and restart on load
    @(posedge clk); #1;
    do_reset();
    run(2, 9, 1'b1);
    run(2, 1, 1'b1);
    hold(2, 2);
    run(2, 3, 1'b1);
    load_step(2, 1'b0, 1'b1, 4'd5, 1'b1);
    run(2, 3, 1'b1);
    load_step(2, 1'b0, 1'b1, 4'd9, 1'b1);
    run(2, 4, 1'b1);

    // clamp, clear priority, clear over a limit tick, async reset mid-count
    @(posedge clk); #1;
    do_reset();
    load_step(0, 1'b0, 1'b1, 4'd15, 1'b1);
    load_step(0, 1'b1, 1'b1, 4'd3, 1'b1);
    load_step(0, 1'b0, 1'b1, 4'd9, 1'b1);
    load_step(0, 1'b1, 1'b0, 4'd0, 1'b1);
    run(0, 1, 1'b0);
    push("s0_pre_rst_q", 9);    check(oq(0));
    push("s0_pre_rst_wrap", 1); check(ow(0));
    do_reset();

    // two-stage BCD cascade
    @(posedge clk); #1;
    do_reset();
    if_lo.enable = 1'b1;
    for (int i = 0; i < 101; i++) begin
      cnt = (i + 1) % 100;
      @(posedge clk); #1;
      push("cas_lo", cnt % 10);   check(32'(if_lo.Q));
      push("cas_hi", cnt / 10);   check(32'(if_hi.Q));
      push("cas_hi_wrap", int'(i == 99)); check(32'(if_hi.wrap));
    end
    if_lo.enable = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_updown_counter.md
Name: sync_updown_counter

Overview:
- Parametrised synchronous counter; next generation of the team's ripple T-flip-flop counter.
- All state bits change on the single clock edge, so there is no ripple skew.
- Adds: up/down direction, arbitrary modulus, wrap or saturate mode, synchronous clear and load, an enable prescaler, and cascade outputs.
- Used as a general timer/event counter and for chaining wide counters.

Parameters:
N, 4, counter width in bits (N >= 1).
MOD, 2**N, count modulus; legal range 0..MOD-1; 2 <= MOD <= 2**N.
SATURATE, 0, 0 = wrap at the limits, 1 = hold at the limits.
PRESCALE, 1, number of enabled cycles per count step (>= 1); 1 = step every enabled cycle.

Ports:
clk  input  1  rising-edge clock; the only clock in the block.
reset_n  input  1  asynchronous, active-low reset.
enable  input  1  count enable; gates the prescaler and counting.
up_down  input  1  1 = count up, 0 = count down; sampled each cycle.
clear  input  1  synchronous clear to 0.
load  input  1  synchronous load of load_value.
load_value  input  N  value for load; values >= MOD are clamped to MOD-1.
Q  output  N  registered count.
tc  output  1  combinational terminal-count/carry: the step on this edge crosses the limit.
wrap  output  1  registered one-cycle pulse, high the cycle after a wrap or saturation hit.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset (reset_n=0, any time, including mid-count): Q=0, prescaler=0, wrap=0, immediately. tc follows its equation, so it is 0 because tick=0.
- Prescaler:
  - Internal counter pcnt, width clog2(PRESCALE), or absent when PRESCALE=1.
  - tick = enable & (pcnt == PRESCALE-1).
  - When enable=1, pcnt increments each cycle and wraps to 0 after PRESCALE-1.
  - When enable=0, pcnt holds.
- Priority per clock edge, highest first: clear > load > tick-step > hold.
  - clear=1: Q<=0, pcnt<=0, wrap<=0.
  - load=1 (clear=0): Q<=min(load_value, MOD-1), pcnt<=0, wrap<=0.
  - tick=1, up_down=1:
    - Q==MOD-1: Q<=0 if SATURATE=0, else Q holds.
    - Otherwise Q<=Q+1.
  - tick=1, up_down=0:
    - Q==0: Q<=MOD-1 if SATURATE=0, else Q holds.
    - Otherwise Q<=Q-1.
  - Otherwise Q holds.
- tc (combinational, for cascading):
  - tc = tick & ~clear & ~load & (up_down ? Q==MOD-1 : Q==0).
  - In saturate mode, tc still asserts while holding at the limit on a tick.
- wrap <= tc, registered. Exactly one cycle high per limit event, asserted in the cycle after the edge. Clear and load force wrap to 0.
- Cascading: the next stage's enable is this stage's tc, with its PRESCALE=1. The chain is fully synchronous.
- Direction change mid-count takes effect on the next tick with no lost step. The prescaler phase is kept.
- Simultaneous clear and load: clear wins.
- load or clear with enable=1: the prescaler restarts, so the first step after load comes PRESCALE enabled cycles later.
- Latency: a Q change is visible one cycle after the tick edge.
- Arithmetic: all compares are N bits wide. MOD-1 is evaluated as a width-N localparam. No overflow beyond MOD-1 is possible.

Decomposition:
- Shared package counter_pkg:
  - Direction constants CNT_DOWN=0, CNT_UP=1.
  - Mode constants MODE_WRAP=0, MODE_SAT=1.
  - clog2 helper function used for the prescaler width.
- One sub-module, tick_prescaler:
  - Parameter PRESCALE.
  - Inputs clk, reset_n, enable, restart. Output tick.
  - Instantiated once; reduces to tick=enable when PRESCALE=1.
- The counter datapath and tc/wrap logic stay in sync_updown_counter.

Test Plan:
1. N=4, MOD=10, PRESCALE=1, wrap mode; enable=1, up_down=1 for 12 cycles from reset.
   -> Q runs 0..9, 0, 1. tc=1 only during Q=9. wrap=1 on the cycle with Q=0 after 9.
2. Same config, down count from reset.
   -> Q goes 0 to 9 on the first tick. tc=1 while Q=0. Q then runs 8, 7, ...
3. SATURATE=1, MOD=10; load_value=8, then count up 4 cycles.
   -> Q=8, 9, 9, 9. tc=1 on each tick at Q=9. wrap pulses each following cycle.
4. PRESCALE=3; enable=1 for 9 cycles.
   -> Q steps 0→1→2→3, one step every 3rd enabled cycle. Deassert enable mid-phase for 2 cycles → Q and the phase hold, no step.
5. load_value=15 with MOD=10 → Q=9. clear and load asserted together → Q=0. reset_n pulsed low mid-count, between edges → Q=0 immediately, wrap=0.
6. Two instances cascaded: N=4, MOD=10 each, upper enable = lower tc; 100 up cycles.
   -> {upper,lower} counts BCD 00..99, then wraps to 00. The upper wrap pulses once.
